rv_regfile_mp: RTL and testbench

Parametrised integer register file for the RV32 cores, the successor of the fixed 2-read/1-write file. It adds:
- configurable data width, depth (RV32E 16 / RV32I 32) and number of read ports;
- an optional same-cycle write-to-read bypass;
- a hardware clear sequencer, because the storage array has no reset.

It sits between decode (read addresses) and writeback (write port) of the single-pipe core.

---
 rtl/rv_regfile_mp_if.sv | 35 +++
 rtl/rv_regfile_mp.sv | 122 ++++++++++++
 tb/tb_rv_regfile_mp.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv_regfile_mp_if.sv
// Register-file port bundle: clear control, writeback port, NRD read ports and status pulses.
// par_err exists only when RV_REGFILE_PARITY_EN is defined.
interface rv_regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NRD  = 2
);
  logic                clr_req;
  logic                rf_ready;
  logic                c_rf_write;
  logic [4:0]          rd_addr;
  logic [XLEN-1:0]     rd_dati;
  logic [NRD*5-1:0]    rs_addr;
  logic [NRD*XLEN-1:0] rs_dato;
  logic                wr_drop;
  logic                addr_err;
`ifdef RV_REGFILE_PARITY_EN
  logic                par_err;
`endif

  modport master (
    output clr_req, c_rf_write, rd_addr, rd_dati, rs_addr,
    input  rf_ready, rs_dato, wr_drop, addr_err
`ifdef RV_REGFILE_PARITY_EN
    , input par_err
`endif
  );

  modport slave (
    input  clr_req, c_rf_write, rd_addr, rd_dati, rs_addr,
    output rf_ready, rs_dato, wr_drop, addr_err
`ifdef RV_REGFILE_PARITY_EN
    , output par_err
`endif
  );
endinterface

// File: rtl/rv_regfile_mp.sv
// Parametrised multi-read-port RV32 register file with clear sweep and optional write bypass.
// Optional even-parity protection per entry: define RV_REGFILE_PARITY_EN.
module rv_regfile_mp #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 32,
  parameter int NRD       = 2,
  parameter int WR_BYPASS = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  rv_regfile_mp_if.slave rf
);
  localparam int         AW     = $clog2(DEPTH);
  localparam logic [5:0] DEPTH6 = 6'(DEPTH);
`ifdef RV_REGFILE_PARITY_EN
  localparam int W = XLEN + 1;
`else
  localparam int W = XLEN;
`endif

  typedef enum logic {CLEAR, READY} state_e;

  state_e                   state_q, state_d;
  logic [AW-1:0]            clr_idx_q, clr_idx_d;
  logic                     wr_drop_q, wr_drop_d;
  logic                     addr_err_q, addr_err_d;
  logic [W-1:0]             mem [DEPTH];

  logic                     rf_ready, rd_oob, commit;
  logic                     mem_we;
  logic [AW-1:0]            mem_wa;
  logic [W-1:0]             mem_wd, core_wd;
  logic [NRD-1:0]           rs_oob, rs_hit, rs_chk;
  logic [NRD-1:0][XLEN-1:0] dato;

  assign rf_ready = (state_q == READY);
  assign rd_oob   = {1'b0, rf.rd_addr} >= DEPTH6;
  assign commit   = rf.c_rf_write && rf_ready && (rf.rd_addr != 5'd0) && !rd_oob;
`ifdef RV_REGFILE_PARITY_EN
  assign core_wd  = {^rf.rd_dati, rf.rd_dati};
`else
  assign core_wd  = rf.rd_dati;
`endif

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [4:0]   a;
    logic [W-1:0] ent;
    assign a         = rf.rs_addr[5*i +: 5];
    assign ent       = mem[a[AW-1:0]];
    assign rs_oob[i] = {1'b0, a} >= DEPTH6;
    // A hit implies a committable write, so it already covers ready/x0/range.
    assign rs_hit[i] = (WR_BYPASS != 0) && commit && (rf.rd_addr == a);
    assign rs_chk[i] = rf_ready && (a != 5'd0) && !rs_oob[i] && !rs_hit[i];
    assign dato[i]   = rs_hit[i] ? rf.rd_dati : (rs_chk[i] ? ent[XLEN-1:0] : '0);
  end
  assign rf.rs_dato = dato;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    mem_we    = 1'b0;
    mem_wa    = rf.rd_addr[AW-1:0];
    mem_wd    = core_wd;
    case (state_q)
      CLEAR: begin
        // All-zero word has even parity, so the sweep also repairs parity.
        mem_we = 1'b1;
        mem_wa = clr_idx_q;
        mem_wd = '0;
        if (rf.clr_req)                           clr_idx_d = AW'(1);
        else if (clr_idx_q == AW'(DEPTH - 1))     state_d   = READY;
        else                                      clr_idx_d = clr_idx_q + AW'(1);
      end
      default: begin
        mem_we = commit;
        if (rf.clr_req) begin
          state_d   = CLEAR;
          clr_idx_d = AW'(1);
        end
      end
    endcase
  end

  assign wr_drop_d  = rf.c_rf_write && (!rf_ready || rd_oob);
  assign addr_err_d = (rf.c_rf_write && rd_oob) || (rf_ready && (|rs_oob));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_idx_q  <= AW'(1);
      wr_drop_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      wr_drop_q  <= wr_drop_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign rf.rf_ready = rf_ready;
  assign rf.wr_drop  = wr_drop_q;
  assign rf.addr_err = addr_err_q;

`ifdef RV_REGFILE_PARITY_EN
  logic [NRD-1:0] par_bad;
  logic           par_err_q;
  for (genvar i = 0; i < NRD; i++) begin : g_par
    assign par_bad[i] = rs_chk[i] && (^g_rd[i].ent);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          par_err_q <= 1'b0;
    else if (rf.clr_req) par_err_q <= 1'b0;
    else if (|par_bad)   par_err_q <= 1'b1;
  end
  assign rf.par_err = par_err_q;
`endif
endmodule

// File: tb/tb_rv_regfile_mp.sv
// Scoreboard bench: two register files (32x4 bypass, 16x2 no bypass) on shared stimulus,
// checked every cycle against a per-file array model of the architectural rules.
module tb_rv_regfile_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b0, clr = 1'b0, wr = 1'b0;
  logic [4:0]      wa = '0;
  logic [31:0]     wd = '0;
  logic [3:0][4:0] rs = '0;
  logic            n_rst = 1'b0, n_clr = 1'b0, n_wr = 1'b0;
  logic [4:0]      n_wa = '0;
  logic [31:0]     n_wd = '0;
  logic [3:0][4:0] n_rs = '0;

  rv_regfile_mp_if #(.XLEN(32), .NRD(4)) ifa ();
  rv_regfile_mp_if #(.XLEN(32), .NRD(2)) ifb ();

  assign ifa.clr_req = clr;  assign ifa.c_rf_write = wr;
  assign ifa.rd_addr = wa;   assign ifa.rd_dati    = wd;
  assign ifa.rs_addr = rs;
  assign ifb.clr_req = clr;  assign ifb.c_rf_write = wr;
  assign ifb.rd_addr = wa;   assign ifb.rd_dati    = wd;
  assign ifb.rs_addr = rs[1:0];

  rv_regfile_mp #(.XLEN(32), .DEPTH(32), .NRD(4), .WR_BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rf(ifa));
  rv_regfile_mp #(.XLEN(32), .DEPTH(16), .NRD(2), .WR_BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rf(ifb));

  // ---------------- reference model ----------------
  logic [31:0] mem_m [2][32];
  bit          corrupt [32];
  int          cnt [2];
  bit          drop_m [2], err_m [2], par_m;

  function automatic int dep(int d); return (d == 0) ? 32 : 16; endfunction
  function automatic int nrd(int d); return (d == 0) ? 4 : 2;   endfunction
  function automatic bit byp(int d); return d == 0;             endfunction

  function automatic bit ready_m(int d);
    return (rst_n === 1'b1) && (cnt[d] == 0);
  endfunction

  function automatic bit commit_m(int d);
    return wr && ready_m(d) && (wa != 0) && (int'(wa) < dep(d));
  endfunction

  function automatic logic [31:0] rd_m(int d, int p);
    int a = int'(rs[p]);
    if (!ready_m(d) || a == 0 || a >= dep(d)) return 32'h0;
    if (byp(d) && commit_m(d) && int'(wa) == a) return wd;
    return mem_m[d][a];
  endfunction

  task automatic reset_m();
    for (int d = 0; d < 2; d++) begin
      cnt[d] = dep(d) - 1; drop_m[d] = 0; err_m[d] = 0;
      for (int k = 0; k < 32; k++) mem_m[d][k] = '0;
    end
    for (int k = 0; k < 32; k++) corrupt[k] = 0;
    par_m = 0;
  endtask

  // State change at a rising edge, using the inputs held during the cycle before it.
  task automatic edge_m();
    bit rdy, oob, rerr, pbad, cm;
    if (rst_n !== 1'b1) return;
    for (int d = 0; d < 2; d++) begin
      rdy = ready_m(d); oob = int'(wa) >= dep(d); cm = commit_m(d);
      rerr = 0; pbad = 0;
      for (int p = 0; p < nrd(d); p++) begin
        if (int'(rs[p]) >= dep(d)) rerr = 1;
        else if (d == 0 && rdy && rs[p] != 0 && corrupt[rs[p]] &&
                 !(byp(d) && cm && wa == rs[p])) pbad = 1;
      end
      drop_m[d] = wr && (!rdy || oob);
      err_m[d]  = (wr && oob) || (rdy && rerr);
      if (d == 0) par_m = clr ? 1'b0 : (par_m | pbad);
      if (cm) begin
        mem_m[d][wa] = wd;
        if (d == 0) corrupt[wa] = 0;
      end
      if (clr) begin
        cnt[d] = dep(d) - 1;
        for (int k = 0; k < 32; k++) mem_m[d][k] = '0;
        if (d == 0) for (int k = 0; k < 32; k++) corrupt[k] = 0;
      end else if (cnt[d] > 0) cnt[d]--;
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0]             rdy;
    logic [1:0][3:0][31:0]  dat;
    logic [1:0]             drop;
    logic [1:0]             err;
    logic                   par;
  } exp_t;
  exp_t q [$];
  int checks = 0, errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e = '0;
    for (int d = 0; d < 2; d++) begin
      e.rdy[d]  = ready_m(d);
      e.drop[d] = drop_m[d];
      e.err[d]  = err_m[d];
      for (int p = 0; p < nrd(d); p++) e.dat[d][p] = rd_m(d, p);
    end
    e.par = par_m;
    q.push_back(e);
  endtask

  // One cycle: commit the past cycle into the model, then drive and predict the next one.
  task automatic step();
    @(posedge clk);
    edge_m();
    #1;
    rst_n = n_rst; clr = n_clr; wr = n_wr; wa = n_wa; wd = n_wd; rs = n_rs;
    n_clr = 0; n_wr = 0;
    if (!rst_n) reset_m();
    push_exp();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rdy_a", 32'(ifa.rf_ready), 32'(e.rdy[0]));
        chk("rdy_b", 32'(ifb.rf_ready), 32'(e.rdy[1]));
        for (int p = 0; p < 4; p++)
          chk($sformatf("dat_a%0d", p), ifa.rs_dato[32*p +: 32], e.dat[0][p]);
        for (int p = 0; p < 2; p++)
          chk($sformatf("dat_b%0d", p), ifb.rs_dato[32*p +: 32], e.dat[1][p]);
        chk("drop_a", 32'(ifa.wr_drop),  32'(e.drop[0]));
        chk("drop_b", 32'(ifb.wr_drop),  32'(e.drop[1]));
        chk("err_a",  32'(ifa.addr_err), 32'(e.err[0]));
        chk("err_b",  32'(ifb.addr_err), 32'(e.err[1]));
`ifdef RV_REGFILE_PARITY_EN
        chk("par_a",  32'(ifa.par_err),  32'(e.par));
`endif
      end
    end
  end

  task automatic wr_cyc(input logic [4:0] a, input logic [31:0] d);
    n_wr = 1; n_wa = a; n_wd = d; step();
  endtask

  task automatic set_rs(input int a0, input int a1, input int a2, input int a3);
    n_rs[0] = 5'(a0); n_rs[1] = 5'(a1); n_rs[2] = 5'(a2); n_rs[3] = 5'(a3);
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    reset_m();
    set_rs(1, 2, 3, 4);
    repeat (3) step();
    n_rst = 1;
    repeat (34) step();                               // sweep length, both depths
    for (int a = 1; a < 32; a += 4) begin set_rs(a, a + 1, a + 2, a + 3); step(); end

    set_rs(5, 0, 1, 2);
    wr_cyc(5'd5, 32'hDEADBEEF); step();
    set_rs(0, 5, 0, 0);
    wr_cyc(5'd0, 32'h12345678); step();

    set_rs(7, 7, 1, 2);                               // same-cycle write/read
    wr_cyc(5'd7, 32'hA5A5A5A5); step(); step();

    wr_cyc(5'd4, 32'h00000044);
    set_rs(4, 5, 0, 0);
    wr_cyc(5'd20, 32'h1);                             // out of range for the 16-deep file
    set_rs(20, 4, 20, 4); step();
    set_rs(4, 1, 0, 0); step(); step();

    wr_cyc(5'd3, 32'hFFFFFFFF);
    set_rs(3, 9, 3, 9);
    n_clr = 1; step();
    repeat (4) step();
    wr_cyc(5'd9, 32'h99999999);                       // dropped during the sweep
    repeat (30) step();
    n_clr = 1; step();
    repeat (10) step();
    n_rst = 0; step(); step();
    n_rst = 1;
    repeat (34) step();

    set_rs(12, 12, 12, 12);
    wr_cyc(5'd12, 32'h0BADF00D); step(); step();
`ifdef RV_REGFILE_PARITY_EN
    dut_a.mem[12] = dut_a.mem[12] ^ 33'h8;
    mem_m[0][12]  = mem_m[0][12] ^ 32'h8;
    corrupt[12]   = 1;
    repeat (3) step();
    set_rs(1, 2, 3, 4); repeat (2) step();
    n_clr = 1; step();
    repeat (3) step();
`endif

    for (int i = 0; i < 1500; i++) begin
      n_rst = ($urandom_range(0, 399) != 0);
      n_clr = ($urandom_range(0, 149) == 0);
      n_wr  = $urandom_range(0, 1);
      n_wa  = 5'($urandom_range(0, 31));
      n_wd  = $urandom;
      for (int p = 0; p < 4; p++) n_rs[p] = 5'($urandom_range(0, 31));
      step();
    end

    n_rst = 1;
    repeat (3) step();
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
